// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module : tdm_pkg
// Desc   : Shared definitions for the TDM mux/demux pair: frame-alignment
//          state encoding and default channel count / channel word width.
// Rev    : 1.0  initial release
// ============================================================================
package tdm_pkg;

  // Default frame geometry, shared by tdm_mux (transmit) and tdm_demux (receive)
  localparam int TDM_N_CH = 4;
  localparam int TDM_W    = 8;

  // Receiver alignment state
  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_t;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module : tdm_demux
// Desc   : Time-division demultiplexer. Reassembles N_CH consecutive channel
//          words (slot 0 flagged by in_sof) into one wide frame, emitted with
//          a single-cycle out_valid pulse. Framing errors pulse err.
// Rev    : 1.0  initial release
// ============================================================================
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH,
  parameter int W    = TDM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  output logic [N_CH*W-1:0] out_data,
  output logic              locked,
  output logic              err
);

  localparam int              SW        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SW-1:0]   LAST_SLOT = SW'(N_CH - 1);

  tdm_state_t        state, state_nx;
  logic [SW-1:0]     slot, slot_nx;
  logic              wr_en;
  logic [SW-1:0]     wr_slot;
  logic              complete;
  logic              err_nx;
  logic [N_CH*W-1:0] merged;

  // A SOF beat always lands in slot 0; any other accepted beat goes to the current slot
  assign wr_slot = in_sof ? '0 : slot;

  // Alignment state and slot counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      slot  <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  // Next-state, slot advance, staging write enable and frame/error detection
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    wr_en    = 1'b0;
    complete = 1'b0;
    err_nx   = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          // Beats without SOF are silently dropped while unaligned
          if (in_sof) begin
            wr_en    = 1'b1;
            slot_nx  = SW'(1);
            state_nx = COLLECT;
          end
        end
        COLLECT: begin
          if (slot == '0) begin
            if (in_sof) begin
              wr_en   = 1'b1;
              slot_nx = SW'(1);
            end else begin
              // Expected a frame start and did not get one: lose alignment
              err_nx   = 1'b1;
              slot_nx  = '0;
              state_nx = HUNT;
            end
          end else if (in_sof) begin
            // Premature SOF: abandon the partial frame, restart at slot 0
            err_nx  = 1'b1;
            wr_en   = 1'b1;
            slot_nx = SW'(1);
          end else begin
            wr_en = 1'b1;
            if (slot == LAST_SLOT) begin
              complete = 1'b1;
              slot_nx  = '0;
            end else begin
              slot_nx = slot + SW'(1);
            end
          end
        end
        default: begin
          state_nx = HUNT;
          slot_nx  = '0;
        end
      endcase
    end
  end

  // Staging bank: one W-bit register per slot, plus the frame view with the
  // current beat bypassed in so the last slot need not be staged first
  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_stage
      logic [W-1:0] word;

      // Capture the beat addressed to this slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word <= '0;
        end else if (wr_en && (wr_slot == SW'(k))) begin
          word <= in_data;
        end
      end

      assign merged[k*W +: W] = (wr_en && (wr_slot == SW'(k))) ? in_data : word;
    end
  endgenerate

  // Registered outputs: frame publish, valid/error pulses and lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      out_valid <= complete;
      err       <= err_nx;
      locked    <= (state_nx == COLLECT);
      if (complete) begin
        out_data <= merged;
      end
    end
  end

endmodule : tdm_demux
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module : tb_tdm_demux
// Desc   : Self-checking bench for tdm_demux (N_CH=4, W=8): directed vector
//          table, hand-written gap/reset sequences, and randomized traffic
//          against a queue-based frame model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_sof;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic [N_CH*W-1:0] out_data;
  logic              locked;
  logic              err;

  int n_checks = 0;
  int n_fails  = 0;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .locked    (locked),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        ov;
    logic [31:0] od;
    logic        er;
    logic        lk;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: aligned flag plus the beats of the frame in progress
  logic        m_aligned;
  logic [7:0]  m_q[$];
  logic        m_ov;
  logic [31:0] m_od;
  logic        m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic s, input logic [7:0] d,
                              input logic ov, input logic [31:0] od,
                              input logic er, input logic lk);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.ov = ov; r.od = od; r.er = er; r.lk = lk;
    tbl.push_back(r);
  endfunction

  function automatic void model_reset();
    m_aligned = 1'b0;
    m_q.delete();
    m_ov  = 1'b0;
    m_od  = '0;
    m_err = 1'b0;
  endfunction

  // Frame-level behaviour: frames are N_CH consecutive accepted beats starting with SOF
  function automatic void model_step(input logic v, input logic s, input logic [7:0] d);
    m_ov  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (s) begin
        if (m_aligned && m_q.size() != 0) m_err = 1'b1;
        m_q.delete();
        m_q.push_back(d);
        m_aligned = 1'b1;
      end else if (m_aligned) begin
        if (m_q.size() == 0) begin
          m_err     = 1'b1;
          m_aligned = 1'b0;
        end else begin
          m_q.push_back(d);
          if (m_q.size() == N_CH) begin
            m_od = '0;
            for (int k = 0; k < N_CH; k++) m_od = m_od | (32'(m_q[k]) << (8 * k));
            m_ov = 1'b1;
            m_q.delete();
          end
        end
      end
    end
  endfunction

  initial begin
    int ov_count;
    int tx;
    logic v, s;
    logic [7:0] d;

    // ---- Vector table (expected values after the edge that takes the beat) ----
    // Pre-lock garbage
    add(1, 0, 8'h99, 0, 32'h0,        0, 0);
    add(1, 0, 8'h98, 0, 32'h0,        0, 0);
    // Clean frame
    add(1, 1, 8'h11, 0, 32'h0,        0, 1);
    add(1, 0, 8'h22, 0, 32'h0,        0, 1);
    add(1, 0, 8'h33, 0, 32'h0,        0, 1);
    add(1, 0, 8'h44, 1, 32'h44332211, 0, 1);
    add(0, 0, 8'h00, 0, 32'h44332211, 0, 1);
    // Missing SOF after lock, then recovery
    add(1, 0, 8'h55, 0, 32'h44332211, 1, 0);
    add(1, 1, 8'hA0, 0, 32'h44332211, 0, 1);
    add(1, 0, 8'hA1, 0, 32'h44332211, 0, 1);
    add(1, 0, 8'hA2, 0, 32'h44332211, 0, 1);
    add(1, 0, 8'hA3, 1, 32'hA3A2A1A0, 0, 1);
    // Premature SOF
    add(1, 1, 8'h01, 0, 32'hA3A2A1A0, 0, 1);
    add(1, 0, 8'h02, 0, 32'hA3A2A1A0, 0, 1);
    add(1, 1, 8'h10, 0, 32'hA3A2A1A0, 1, 1);
    add(1, 0, 8'h20, 0, 32'hA3A2A1A0, 0, 1);
    add(1, 0, 8'h30, 0, 32'hA3A2A1A0, 0, 1);
    add(1, 0, 8'h40, 1, 32'h40302010, 0, 1);
    // Back-to-back frames at full rate
    add(1, 1, 8'hC0, 0, 32'h40302010, 0, 1);
    add(1, 0, 8'hC1, 0, 32'h40302010, 0, 1);
    add(1, 0, 8'hC2, 0, 32'h40302010, 0, 1);
    add(1, 0, 8'hC3, 1, 32'hC3C2C1C0, 0, 1);
    add(1, 1, 8'hD0, 0, 32'hC3C2C1C0, 0, 1);
    add(1, 0, 8'hD1, 0, 32'hC3C2C1C0, 0, 1);
    add(1, 0, 8'hD2, 0, 32'hC3C2C1C0, 0, 1);
    add(1, 0, 8'hD3, 1, 32'hD3D2D1D0, 0, 1);
    add(0, 0, 8'h00, 0, 32'hD3D2D1D0, 0, 1);

    // ---- Reset state ----
    do_reset();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset err",       64'(err),       64'd0);
    check("reset locked",    64'(locked),    64'd0);

    // ---- Table-driven vectors ----
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      check($sformatf("vec%0d out_data",  i), 64'(out_data),  64'(tbl[i].od));
      check($sformatf("vec%0d err",       i), 64'(err),       64'(tbl[i].er));
      check($sformatf("vec%0d locked",    i), 64'(locked),    64'(tbl[i].lk));
    end

    // ---- Gapped frame: 3 idle cycles between beats ----
    ov_count = 0;
    for (int b = 0; b < 4; b++) begin
      step(1'b1, (b == 0), 8'((b + 1) * 8'h11));
      check($sformatf("gap beat%0d out_valid", b), 64'(out_valid), 64'(b == 3));
      check($sformatf("gap beat%0d err", b), 64'(err), 64'd0);
      if (out_valid) ov_count++;
      if (b == 3) check("gap out_data", 64'(out_data), 64'h44332211);
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 8'hEE);
        check("gap idle out_valid", 64'(out_valid), 64'd0);
        check("gap idle locked", 64'(locked), 64'd1);
        if (out_valid) ov_count++;
      end
    end
    check("gap pulse count", 64'(ov_count), 64'd1);
    check("gap out_data held", 64'(out_data), 64'h44332211);

    // ---- Asynchronous reset mid-frame ----
    step(1'b1, 1'b1, 8'hB1);
    step(1'b1, 1'b0, 8'hB2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst out_data",  64'(out_data),  64'd0);
    check("async rst err",       64'(err),       64'd0);
    check("async rst locked",    64'(locked),    64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'hB3);
    check("post-rst B3 out_valid", 64'(out_valid), 64'd0);
    check("post-rst B3 locked",    64'(locked),    64'd0);
    check("post-rst B3 err",       64'(err),       64'd0);
    step(1'b1, 1'b0, 8'hB4);
    check("post-rst B4 out_valid", 64'(out_valid), 64'd0);
    check("post-rst B4 locked",    64'(locked),    64'd0);
    check("post-rst B4 out_data",  64'(out_data),  64'd0);

    // ---- Randomized traffic against the frame model ----
    do_reset();
    model_reset();
    tx = 0;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = 1'b0;
      d = 8'($urandom);
      if (v) begin
        s = (tx == 0);
        if ($urandom_range(0, 15) == 0) s = ~s;
        tx = s ? 1 : (tx + 1) % N_CH;
      end
      model_step(v, s, d);
      step(v, s, d);
      check($sformatf("rnd%0d out_valid", n), 64'(out_valid), 64'(m_ov));
      check($sformatf("rnd%0d out_data",  n), 64'(out_data),  64'(m_od));
      check($sformatf("rnd%0d err",       n), 64'(err),       64'(m_err));
      check($sformatf("rnd%0d locked",    n), 64'(locked),    64'(m_aligned));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_tdm_demux
`default_nettype wire

// File: doc/tdm_demux.md
# tdm_demux

Sequential time-division demultiplexer: the receive-side counterpart of a TDM multiplexer. It accepts one narrow word stream in which successive words belong to successive channels, with slot 0 marked by a start-of-frame flag. It reassembles each frame into a wide parallel word and presents the complete frame with a one-cycle valid pulse. It sits directly behind a TDM serializing mux, on the same clock.

## Interface
- `N_CH`, default 4: channels (slots) per frame; must be ≥ 2.
- `W`, default 8: width of one channel word.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` / `in_sof` carry a beat this cycle.
- `in_sof` input 1: beat is slot 0 of a frame; qualified by `in_valid`.
- `in_data` input W: channel word for the current slot.
- `out_valid` output 1: one-cycle pulse, new frame on `out_data`.
- `out_data` output N_CH*W: last complete frame; channel k at bits [k*W +: W].
- `locked` output 1: high while in COLLECT state.
- `err` output 1: one-cycle pulse on framing error.

## Operation
- Two states: HUNT (no frame alignment) and COLLECT (aligned, slot counter meaningful).
- `slot` counter, width $clog2(N_CH), range 0..N_CH-1.
- Staging bank: N_CH words of W, written per beat. It is copied to `out_data` atomically only on frame completion.
- HUNT, beat with `in_sof`=1: store to stage[0], `slot`←1, go COLLECT.
- HUNT, beat with `in_sof`=0: drop the beat. No `err`.
- COLLECT, beat, `slot`=0, `in_sof`=1: store to stage[0], `slot`←1.
- COLLECT, beat, `slot`=0, `in_sof`=0: pulse `err`, drop the beat, go HUNT.
- COLLECT, beat, `slot`≠0, `in_sof`=0: store to stage[slot].
  - If `slot`=N_CH-1, the frame is complete: `out_data` ← stage with this beat merged, pulse `out_valid`, `slot`←0.
  - Otherwise `slot`←`slot`+1.
- COLLECT, beat, `slot`≠0, `in_sof`=1 (premature SOF): pulse `err`, discard the partial frame, treat this beat as slot 0 (stage[0], `slot`←1), stay COLLECT.
- `in_valid`=0: nothing changes. Gaps of any length are legal; there is no timeout.
- Stale staging words from a discarded frame are never emitted. Every emitted frame consists of N_CH consecutive accepted beats starting with SOF.
- No backpressure: every valid beat is consumed in its cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `err`=0, `locked`=0, state HUNT, `slot`=0, staging bank 0.
- Reset takes effect immediately, mid-frame included. The partial frame is lost, and after release the block hunts for the next SOF.
- Latency: `out_valid` and new `out_data` appear in the cycle after the clock edge that accepts the last slot's beat (registered outputs, 1 cycle).
- `out_data` holds until the next completed frame; it does not change on `err`.
- `err` is registered and asserts in the cycle after the offending beat. It never coincides with `out_valid` for the same beat.
- Back-to-back frames at full rate: `out_valid` every N_CH cycles; no bubble required between frames.
- `locked` is registered and reflects the state after each edge.

## Structure
- Shared package `tdm_pkg` holds the state enum (HUNT, COLLECT) and the default `N_CH`/`W` localparams, shared with the transmitting `tdm_mux`.
- No sub-module required. State/slot control and the staging bank live in one module; the bank is a generate loop of W-bit registers written by slot decode.

## Test plan
All scenarios use N_CH=4, W=8.

- Reset then one clean frame: 0x11(sof), 0x22, 0x33, 0x44 on consecutive cycles → one `out_valid` pulse the next cycle, `out_data`=0x44332211, `err` never high, `locked`=1 from cycle after the first beat.
- Gapped frame: the same four beats with 3 idle cycles between each → identical `out_data`, single `out_valid` one cycle after the 0x44 beat.
- Missing SOF after lock: a frame completes, then 0x55 without SOF → `err` pulse, `locked`=0, `out_data` unchanged. Then 0xA0(sof), 0xA1, 0xA2, 0xA3 → `out_data`=0xA3A2A1A0.
- Premature SOF: 0x01(sof), 0x02, then 0x10(sof), 0x20, 0x30, 0x40 → one `err` pulse after the 0x10 beat, exactly one frame emitted, `out_data`=0x40302010.
- Pre-lock garbage: 0x99, 0x98 without SOF right after reset → no `err`, no `out_valid`, `locked`=0. A following clean frame is decoded correctly.
- Async reset mid-frame: drop `rst_n` after 2 beats of a frame → all outputs 0 immediately. After release, the remaining 2 beats (no SOF) are dropped with no `out_valid`.
